// File: rtl/pong_pkg.sv
// Shared types and default timing for the pong input path: paddle move states
// and the debounce / auto-repeat periods used when no override is given.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } move_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned REPEAT_CYCLES_DEF   = 100000;

  // Up+down together is treated as no command, same as neither pressed.
  function automatic move_state_t resolve_dir(input logic up, input logic dn);
    case ({up, dn})
      2'b10:   return UP;
      2'b01:   return DOWN;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: two-flop synchronizer followed by a counter debouncer that
// accepts a new level only after it has been stable for DEBOUNCE_CYCLES clocks.
module button_debounce
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic q
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Any return to the accepted level restarts the qualification window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (s2 == q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      q   <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/paddle_input_conditioner.sv
// Conditions the four paddle buttons into per-player move strobes: debounced,
// conflict-resolved, and auto-repeated at a fixed rate while a direction is held.
module paddle_input_conditioner
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_p1_up,
  input  logic btn_p1_down,
  input  logic btn_p2_up,
  input  logic btn_p2_down,
  output logic p1_up,
  output logic p1_down,
  output logic p2_up,
  output logic p2_down,
  output logic p1_active,
  output logic p2_active
);

  localparam int unsigned      REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [1:0] raw_up;
  logic [1:0] raw_dn;
  logic [1:0] up_q;
  logic [1:0] dn_q;
  logic [1:0] strb_up;
  logic [1:0] strb_dn;
  logic [1:0] active;

  assign raw_up = {btn_p2_up,   btn_p1_up};
  assign raw_dn = {btn_p2_down, btn_p1_down};

  for (genvar p = 0; p < 2; p++) begin : g_player
    move_state_t      state;
    move_state_t      state_nxt;
    logic [REP_W-1:0] rep;
    logic [REP_W-1:0] rep_nxt;
    logic             fire;
    logic             up_nxt;
    logic             dn_nxt;
    logic             up_r;
    logic             dn_r;
    logic             act_r;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
      .clk   (clk),
      .reset (reset),
      .btn   (raw_up[p]),
      .q     (up_q[p])
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_db (
      .clk   (clk),
      .reset (reset),
      .btn   (raw_dn[p]),
      .q     (dn_q[p])
    );

    // Entering a direction (including a direct reversal) strobes at once and
    // restarts the repeat phase at 1, so the next strobe lands REPEAT_CYCLES later.
    always_comb begin
      state_nxt = resolve_dir(up_q[p], dn_q[p]);
      rep_nxt   = '0;
      fire      = 1'b0;
      if (state_nxt != IDLE) begin
        if (state_nxt != state) begin
          fire    = 1'b1;
          rep_nxt = REP_W'(1);
        end else begin
          fire    = (rep == '0);
          rep_nxt = (rep == REP_LAST) ? '0 : rep + REP_W'(1);
        end
      end
      up_nxt = fire && (state_nxt == UP);
      dn_nxt = fire && (state_nxt == DOWN);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= IDLE;
        rep   <= '0;
        up_r  <= 1'b0;
        dn_r  <= 1'b0;
        act_r <= 1'b0;
      end else begin
        state <= state_nxt;
        rep   <= rep_nxt;
        up_r  <= up_nxt;
        dn_r  <= dn_nxt;
        act_r <= (state_nxt != IDLE);
      end
    end

    assign strb_up[p] = up_r;
    assign strb_dn[p] = dn_r;
    assign active[p]  = act_r;
  end

  assign p1_up     = strb_up[0];
  assign p1_down   = strb_dn[0];
  assign p2_up     = strb_up[1];
  assign p2_down   = strb_dn[1];
  assign p1_active = active[0];
  assign p2_active = active[1];

endmodule
